// File: rtl/hazard_ctrl_if.sv
// Hazard controller signal bundle: ID/EX hazard sources in, pipeline
// stall/flush controls and mult/div sequencer status out.
interface hazard_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_uses_rt;
   logic             id_hilo_use;
   logic             ex_mem_read;
   logic [4:0]       ex_rt;
   logic             ex_branch_taken;
   logic             md_start;
   logic             md_is_div;
   logic             imem_ready;
   logic             pc_stall;
   logic             if_id_stall;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic             md_busy;
   logic             md_done;
   logic             md_overrun;
   logic [CNT_W-1:0] stall_count;

   // Pipeline side: supplies hazard sources, consumes controls.
   modport master (
      output id_rs, id_rt, id_uses_rt, id_hilo_use, ex_mem_read, ex_rt,
             ex_branch_taken, md_start, md_is_div, imem_ready,
      input  pc_stall, if_id_stall, if_id_flush, id_ex_flush,
             md_busy, md_done, md_overrun, stall_count
   );

   // Controller side.
   modport slave (
      input  id_rs, id_rt, id_uses_rt, id_hilo_use, ex_mem_read, ex_rt,
             ex_branch_taken, md_start, md_is_div, imem_ready,
      output pc_stall, if_id_stall, if_id_flush, id_ex_flush,
             md_busy, md_done, md_overrun, stall_count
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS32 pipeline. Combinational
// stall/flush priority logic, a mult/div busy sequencer and a stall-cycle
// counter.
module hazard_ctrl #(
   parameter int unsigned MUL_LAT = 4,
   parameter int unsigned DIV_LAT = 32,
   parameter int unsigned CNT_W   = 32
) (
   input logic         clk,
   input logic         reset,
   hazard_ctrl_if.slave hz
);

   localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int unsigned CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
   localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);
   localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT - 1);

   typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;

   md_state_e        state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             overrun_q, overrun_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;

   logic load_use, md_hazard;
   logic pc_stall, if_id_stall, if_id_flush, id_ex_flush;

   // Stall/flush priority: reset, taken branch, data hazard, fetch wait.
   always_comb begin
      load_use  = hz.ex_mem_read && (hz.ex_rt != '0) &&
                  ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));
      md_hazard = (state_q == MD_BUSY) && hz.id_hilo_use;
      pc_stall    = 1'b0;
      if_id_stall = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      if (!reset) begin
         pc_stall    = 1'b1;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (hz.ex_branch_taken) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (load_use || md_hazard) begin
         pc_stall    = 1'b1;
         if_id_stall = 1'b1;
         id_ex_flush = 1'b1;
      end else if (!hz.imem_ready) begin
         pc_stall    = 1'b1;
         if_id_flush = 1'b1;
      end
   end

   // Mult/div sequencer next state; a start while busy is dropped and flagged.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      overrun_d = overrun_q;
      case (state_q)
         MD_IDLE, MD_DONE: begin
            if (hz.md_start) begin
               state_d = MD_BUSY;
               cnt_d   = hz.md_is_div ? DIV_CNT : MUL_CNT;
            end else begin
               state_d = MD_IDLE;
            end
         end
         MD_BUSY: begin
            if (hz.md_start) overrun_d = 1'b1;
            if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            else             state_d = MD_DONE;
         end
         default: state_d = MD_IDLE;
      endcase
   end

   // Stall counter next value; wraps naturally at 2^CNT_W.
   always_comb begin
      stall_count_d = stall_count_q;
      if (pc_stall) stall_count_d = stall_count_q + CNT_W'(1);
   end

   // State, counters and sticky overrun; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= MD_IDLE;
         cnt_q         <= '0;
         overrun_q     <= 1'b0;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         overrun_q     <= overrun_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign hz.pc_stall    = pc_stall;
   assign hz.if_id_stall = if_id_stall;
   assign hz.if_id_flush = if_id_flush;
   assign hz.id_ex_flush = id_ex_flush;
   assign hz.md_busy     = (state_q == MD_BUSY);
   assign hz.md_done     = (state_q == MD_DONE);
   assign hz.md_overrun  = overrun_q;
   assign hz.stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: time-window model of the mult/div unit plus
// directed vectors with literal expectations.
module tb_hazard_ctrl;
   localparam int MUL = 4;
   localparam int DIV = 32;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;

   hazard_ctrl_if #(.CNT_W(4)) hz();

   hazard_ctrl #(.MUL_LAT(MUL), .DIV_LAT(DIV), .CNT_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- model: operation windows in cycle numbers ----------------
   int cyc = 0;
   int bs = -1, be = -2, dn = -1;
   bit m_ovr = 0;
   int m_cnt = 0;

   function automatic bit m_busy();
      return (cyc >= bs) && (cyc <= be);
   endfunction

   function automatic bit m_done();
      return cyc == dn;
   endfunction

   function automatic void exp_ctrl(output bit ps, output bit is, output bit ifl, output bit ief);
      bit lu, mh;
      lu = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
           ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));
      mh = m_busy() && hz.id_hilo_use;
      ps = 0; is = 0; ifl = 0; ief = 0;
      if (!reset)                   begin ps = 1; ifl = 1; ief = 1; end
      else if (hz.ex_branch_taken)  begin ifl = 1; ief = 1; end
      else if (lu || mh)            begin ps = 1; is = 1; ief = 1; end
      else if (!hz.imem_ready)      begin ps = 1; ifl = 1; end
   endfunction

   always @(posedge clk or negedge reset) begin
      bit ps, is, ifl, ief;
      int lat;
      if (!reset) begin
         bs = -1; be = -2; dn = -1; m_ovr = 0; m_cnt = 0;
      end else begin
         exp_ctrl(ps, is, ifl, ief);
         if (ps) m_cnt = (m_cnt + 1) % 16;
         if (hz.md_start) begin
            if (m_busy()) m_ovr = 1;
            else begin
               lat = hz.md_is_div ? DIV : MUL;
               bs = cyc + 1; be = cyc + lat; dn = cyc + lat + 1;
            end
         end
         cyc++;
      end
   end

   // Compare process: every output against the model, mid-cycle.
   always @(negedge clk) begin
      bit ps, is, ifl, ief;
      exp_ctrl(ps, is, ifl, ief);
      chk("cmp_pc_stall",    32'(hz.pc_stall),    32'(ps));
      chk("cmp_if_id_stall", 32'(hz.if_id_stall), 32'(is));
      chk("cmp_if_id_flush", 32'(hz.if_id_flush), 32'(ifl));
      chk("cmp_id_ex_flush", 32'(hz.id_ex_flush), 32'(ief));
      chk("cmp_md_busy",     32'(hz.md_busy),     32'(m_busy()));
      chk("cmp_md_done",     32'(hz.md_done),     32'(m_done()));
      chk("cmp_md_overrun",  32'(hz.md_overrun),  32'(m_ovr));
      chk("cmp_stall_count", 32'(hz.stall_count), 32'(m_cnt));
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ctl(input string nm, input bit ps, input bit is, input bit ifl, input bit ief);
      #1;
      chk({nm, "_pc_stall"},    32'(hz.pc_stall),    32'(ps));
      chk({nm, "_if_id_stall"}, 32'(hz.if_id_stall), 32'(is));
      chk({nm, "_if_id_flush"}, 32'(hz.if_id_flush), 32'(ifl));
      chk({nm, "_id_ex_flush"}, 32'(hz.id_ex_flush), 32'(ief));
   endtask

   task automatic clear_inputs();
      hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.id_uses_rt = 1'b0; hz.id_hilo_use = 1'b0;
      hz.ex_mem_read = 1'b0; hz.ex_rt = 5'd0; hz.ex_branch_taken = 1'b0;
      hz.md_start = 1'b0; hz.md_is_div = 1'b0; hz.imem_ready = 1'b1;
   endtask

   initial begin
      int dcount;
      reset = 1'b0;
      clear_inputs();
      // reset state
      ctl("rst", 1, 0, 1, 1);
      chk("rst_md_busy", 32'(hz.md_busy), 0);
      chk("rst_md_done", 32'(hz.md_done), 0);
      chk("rst_md_overrun", 32'(hz.md_overrun), 0);
      chk("rst_stall_count", 32'(hz.stall_count), 0);
      #20 reset = 1'b1;
      tick();

      // load-use vectors
      hz.ex_mem_read = 1; hz.ex_rt = 5; hz.id_rs = 5; hz.id_rt = 3;
      ctl("lu_rs", 1, 1, 0, 1);
      hz.ex_rt = 0; hz.id_rs = 0;
      ctl("lu_r0", 0, 0, 0, 0);
      hz.ex_rt = 5; hz.id_rs = 3; hz.id_rt = 5; hz.id_uses_rt = 0;
      ctl("lu_rt_unused", 0, 0, 0, 0);
      hz.id_uses_rt = 1;
      ctl("lu_rt_used", 1, 1, 0, 1);
      // branch overrides load-use and fetch wait; md_start still accepted
      hz.ex_branch_taken = 1; hz.imem_ready = 0; hz.md_start = 1; hz.md_is_div = 0;
      ctl("br_prio", 0, 0, 1, 1);
      tick();
      clear_inputs();
      chk("br_md_accept", 32'(hz.md_busy), 1);
      repeat (5) tick();
      chk("br_md_idle", 32'(hz.md_busy), 0);

      // mult latency with HI/LO hazard
      hz.md_start = 1; hz.md_is_div = 0;
      tick();
      hz.md_start = 0; hz.id_hilo_use = 1;
      for (int k = 1; k <= 6; k++) begin
         #1;
         chk("mul_busy", 32'(hz.md_busy), 32'((k >= 1 && k <= 4) ? 1 : 0));
         chk("mul_done", 32'(hz.md_done), 32'((k == 5) ? 1 : 0));
         chk("mul_hilo_stall", 32'(hz.pc_stall), 32'((k <= 4) ? 1 : 0));
         tick();
      end
      clear_inputs();

      // div back-to-back and overrun
      hz.md_start = 1; hz.md_is_div = 1;
      for (int k = 1; k <= 70; k++) begin
         tick();
         hz.md_start = (k == 33 || k == 40);
         #1;
         chk("div_busy", 32'(hz.md_busy), 32'(((k >= 1 && k <= 32) || (k >= 34 && k <= 65)) ? 1 : 0));
         chk("div_done", 32'(hz.md_done), 32'((k == 33 || k == 66) ? 1 : 0));
         chk("div_overrun", 32'(hz.md_overrun), 32'((k >= 41) ? 1 : 0));
      end
      clear_inputs();
      repeat (3) tick();
      chk("ovr_sticky", 32'(hz.md_overrun), 1);

      // async reset in the middle of a divide
      chk("pre_cnt", 32'(hz.stall_count), 32'(m_cnt));
      hz.md_start = 1; hz.md_is_div = 1;
      tick();
      hz.md_start = 0; hz.imem_ready = 0;
      tick();
      tick();
      hz.imem_ready = 1;
      repeat (17) tick();
      chk("mid_busy", 32'(hz.md_busy), 1);
      chk("mid_ovr", 32'(hz.md_overrun), 1);
      #3 reset = 1'b0;
      ctl("async_rst", 1, 0, 1, 1);
      chk("async_busy", 32'(hz.md_busy), 0);
      chk("async_cnt", 32'(hz.stall_count), 0);
      chk("async_ovr", 32'(hz.md_overrun), 0);
      tick();
      tick();
      #3 reset = 1'b1;
      dcount = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (hz.md_done || hz.md_busy) dcount++;
      end
      chk("no_done_after_rst", 32'(dcount), 0);

      // fetch wait and stall counter wrap
      chk("imem_cnt0", 32'(hz.stall_count), 0);
      hz.imem_ready = 0;
      for (int i = 1; i <= 3; i++) begin
         ctl("imem", 1, 0, 1, 0);
         tick();
         chk("imem_cnt", 32'(hz.stall_count), 32'(i));
      end
      repeat (12) tick();
      chk("cnt_15", 32'(hz.stall_count), 15);
      tick();
      chk("cnt_wrap", 32'(hz.stall_count), 0);
      hz.imem_ready = 1;
      ctl("imem_ok", 0, 0, 0, 0);

      // first start after reset is accepted
      hz.md_start = 1; hz.md_is_div = 0;
      tick();
      hz.md_start = 0;
      chk("post_rst_start", 32'(hz.md_busy), 1);
      repeat (6) tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
